// File: rtl/adc_scan_tx.sv
// N-channel ADC scan sequencer: walks the enabled channels, converts each one
// and streams every sample to the byte transmitter as {A,ch} + MSB-first data.
module adc_scan_tx #(
  parameter int NCH    = 2,
  parameter int CH_W   = 1,
  parameter int DATA_W = 12,
  parameter int PERIOD = 100000,
  parameter int TMR_W  = 17
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              mode_i,
  input  logic [NCH-1:0]    ch_mask_i,
  output logic              spi_start_o,
  output logic [CH_W-1:0]   spi_ch_o,
  input  logic              spi_done_i,
  input  logic [DATA_W-1:0] spi_data_i,
  output logic              tx_start_o,
  output logic [7:0]        tx_data_o,
  input  logic              tx_busy_i,
  output logic              busy_o,
  output logic              eoa_o,
  output logic              ovr_o
);

  localparam int NB    = (DATA_W + 7) / 8;
  localparam int EXT_W = 8 * NB;
  localparam int PTR_W = CH_W + 1;
  localparam int IDX_W = $clog2(NB + 2);

  typedef enum logic [3:0] {
    S_IDLE, S_SEEK, S_CONV, S_WAIT_SPI, S_SEND,
    S_WAIT_TXH, S_WAIT_TXL, S_DONE, S_WAIT_PER
  } state_t;

  state_t            state, state_d;
  logic [PTR_W-1:0]  ptr;
  logic [IDX_W-1:0]  idx;
  logic [NCH-1:0]    mask_r;
  logic              mode_r, stop_r, pend_r, ovr_r;
  logic [TMR_W-1:0]  timer;
  logic [DATA_W-1:0] data_r;
  logic              tx_start_r;
  logic [7:0]        tx_data_r;

  logic              start_ok, tmr_hit, ptr_end, ch_sel, tx_fire, last_byte;
  logic [NCH-1:0]    mask_sh;
  logic [EXT_W-1:0]  ext;
  logic [7:0]        byte_sel;

  assign start_ok  = start_i && (|ch_mask_i);
  assign tmr_hit   = mode_r && (state != S_IDLE) && (timer == TMR_W'(PERIOD - 1));
  assign ptr_end   = ptr >= PTR_W'(NCH);
  assign mask_sh   = mask_r >> ptr;
  assign ch_sel    = mask_sh[0];
  assign tx_fire   = (state == S_SEND) && !tx_busy_i;
  assign last_byte = idx == IDX_W'(NB);
  assign ext       = EXT_W'(data_r);

  always_comb begin
    // NOTE: defaults first so every path assigns each output (no latches).
    byte_sel = {4'hA, 4'(ptr)};
    if (idx != '0) byte_sel = 8'(ext >> (8 * (NB - int'(idx))));
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:     if (start_ok) state_d = S_SEEK;
      S_SEEK:     if (ptr_end) state_d = S_DONE;
                  else if (ch_sel) state_d = S_CONV;
      S_CONV:     state_d = S_WAIT_SPI;
      S_WAIT_SPI: if (spi_done_i) state_d = S_SEND;
      S_SEND:     if (!tx_busy_i) state_d = S_WAIT_TXH;
      S_WAIT_TXH: if (tx_busy_i) state_d = S_WAIT_TXL;
      S_WAIT_TXL: if (!tx_busy_i) state_d = last_byte ? S_SEEK : S_SEND;
      // A period that expired mid-scan restarts immediately, skipping WAIT_PER.
      S_DONE:     if (!mode_r || stop_r) state_d = S_IDLE;
                  else if (pend_r || tmr_hit) state_d = S_SEEK;
                  else state_d = S_WAIT_PER;
      S_WAIT_PER: if (stop_r) state_d = S_IDLE;
                  else if (tmr_hit) state_d = S_SEEK;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= S_IDLE;
      ptr        <= '0;
      idx        <= '0;
      mask_r     <= '0;
      mode_r     <= 1'b0;
      stop_r     <= 1'b0;
      pend_r     <= 1'b0;
      ovr_r      <= 1'b0;
      timer      <= '0;
      data_r     <= '0;
      tx_start_r <= 1'b0;
      tx_data_r  <= '0;
    end else begin
      // NOTE: non-blocking throughout so every register sees pre-edge values.
      state      <= state_d;
      tx_start_r <= tx_fire;
      if (tx_fire) tx_data_r <= byte_sel;

      if (state == S_IDLE) begin
        if (start_ok) begin
          mask_r <= ch_mask_i;
          mode_r <= mode_i;
          ptr    <= '0;
          stop_r <= 1'b0;
          pend_r <= 1'b0;
          ovr_r  <= 1'b0;
          timer  <= '0;
        end
      end else begin
        if (stop_i) stop_r <= 1'b1;
        if (mode_r) begin
          if (tmr_hit) begin
            timer <= '0;
            if (state != S_WAIT_PER) begin
              ovr_r  <= 1'b1;
              pend_r <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
      end

      if (state == S_SEEK && !ptr_end && !ch_sel) ptr <= ptr + 1'b1;
      if (state == S_WAIT_SPI && spi_done_i) begin
        data_r <= spi_data_i;
        idx    <= '0;
      end
      if (state == S_WAIT_TXL && !tx_busy_i) begin
        if (last_byte) ptr <= ptr + 1'b1;
        else idx <= idx + 1'b1;
      end
      if ((state == S_DONE || state == S_WAIT_PER) && state_d == S_SEEK) begin
        ptr    <= '0;
        pend_r <= 1'b0;
      end
    end
  end

  assign spi_start_o = state == S_CONV;
  assign spi_ch_o    = ptr[CH_W-1:0];
  assign busy_o      = state != S_IDLE;
  assign eoa_o       = state == S_DONE;
  assign ovr_o       = ovr_r;
  assign tx_start_o  = tx_start_r;
  assign tx_data_o   = tx_data_r;

endmodule

// File: tb/tb_adc_scan_tx.sv
// Directed bench for adc_scan_tx: ADC and transmitter stubs plus logs of the
// converted channels and transmitted bytes, compared against hand-built frames.
module tb_adc_scan_tx;

  localparam int NCH = 4, CH_W = 2, DATA_W = 12, PERIOD = 2000, TMR_W = 17;

  logic              clk_i = 1'b0, rst_i = 1'b0;
  logic              start_i = 1'b0, stop_i = 1'b0, mode_i = 1'b0;
  logic [NCH-1:0]    ch_mask_i = '0;
  logic              spi_start_o, spi_done_i = 1'b0;
  logic [CH_W-1:0]   spi_ch_o;
  logic [DATA_W-1:0] spi_data_i = '0;
  logic              tx_start_o, tx_busy_i = 1'b0;
  logic [7:0]        tx_data_o;
  logic              busy_o, eoa_o, ovr_o;

  adc_scan_tx #(.NCH(NCH), .CH_W(CH_W), .DATA_W(DATA_W), .PERIOD(PERIOD), .TMR_W(TMR_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i), .mode_i(mode_i),
    .ch_mask_i(ch_mask_i), .spi_start_o(spi_start_o), .spi_ch_o(spi_ch_o),
    .spi_done_i(spi_done_i), .spi_data_i(spi_data_i), .tx_start_o(tx_start_o),
    .tx_data_o(tx_data_o), .tx_busy_i(tx_busy_i), .busy_o(busy_o), .eoa_o(eoa_o),
    .ovr_o(ovr_o)
  );

  always #5 clk_i = ~clk_i;

  logic [7:0]      tx_log[$];
  logic [CH_W-1:0] ch_log[$];
  int              t0_log[$];
  int              cyc = 0, eoa_cnt = 0, tx_len = 1, tx_cnt = 0;
  int              adc_cnt = 0, spur_cnt = 0;
  logic [CH_W-1:0] adc_ch = '0;
  logic            spur_en = 1'b0;
  int              n_checks = 0, n_pass = 0, guard = 0;

  function automatic logic [DATA_W-1:0] adc_val(input logic [CH_W-1:0] ch);
    case (ch)
      2'd0:    return 12'hABC;
      2'd1:    return 12'h123;
      2'd2:    return 12'h456;
      default: return 12'h789;
    endcase
  endfunction

  // Peripheral stubs and monitors, evaluated 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk_i); #1;
      cyc++;
      spi_done_i = 1'b0;
      if (!rst_i) begin
        tx_busy_i = 1'b0; tx_cnt = 0; adc_cnt = 0; spur_cnt = 0;
      end else begin
        if (tx_start_o) tx_log.push_back(tx_data_o);
        if (tx_cnt > 0) begin
          tx_cnt--;
          if (tx_cnt == 0) tx_busy_i = 1'b0;
        end else if (tx_start_o) begin
          tx_busy_i = 1'b1; tx_cnt = tx_len;
        end
        if (spi_start_o) begin
          ch_log.push_back(spi_ch_o);
          if (spi_ch_o == 0) t0_log.push_back(cyc);
          adc_cnt = 3; adc_ch = spi_ch_o;
        end else if (adc_cnt > 0) begin
          adc_cnt--;
          if (adc_cnt == 0) begin
            spi_done_i = 1'b1; spi_data_i = adc_val(adc_ch);
            if (spur_en) spur_cnt = 2;
          end
        end else if (spur_cnt > 0) begin
          spur_cnt--;
          if (spur_cnt == 0) begin spi_done_i = 1'b1; spi_data_i = 12'hFFF; end
        end
        if (eoa_o) eoa_cnt++;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk_i); #2; end
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic pulse_start(input logic m, input logic [NCH-1:0] mk);
    mode_i = m; ch_mask_i = mk; start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_i = 1'b1; tick(); stop_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy_o && n < budget) begin tick(); n++; end
    check({tag, "_idle"}, busy_o, 0);
  endtask

  task automatic clear_logs();
    tx_log.delete(); ch_log.delete(); t0_log.delete(); eoa_cnt = 0;
  endtask

  task automatic check_frame(input string tag, input int n, input logic [63:0] exp);
    check({tag, "_nbytes"}, tx_log.size(), n);
    for (int i = 0; i < n; i++)
      if (i < tx_log.size()) check($sformatf("%s_b%0d", tag, i), tx_log[i], exp[8*(n-1-i) +: 8]);
  endtask

  initial begin
    tick(3);
    check("rst_outputs", {busy_o, spi_start_o, spi_ch_o, tx_start_o, tx_data_o, eoa_o, ovr_o}, 0);
    rst_i = 1'b1;
    tick(2);

    // Two-channel single scan; a stray spi_done mid-frame must not corrupt data.
    clear_logs(); spur_en = 1'b1;
    pulse_start(1'b0, 4'b0011);
    check("single_busy", busy_o, 1);
    wait_idle("single", 300);
    check_frame("single", 6, 48'hA0_0A_BC_A1_01_23);
    check("single_eoa", eoa_cnt, 1);
    spur_en = 1'b0;

    clear_logs();
    pulse_start(1'b0, 4'b0010);
    wait_idle("m0010", 300);
    check("m0010_nconv", ch_log.size(), 1);
    if (ch_log.size() > 0) check("m0010_ch", ch_log[0], 1);
    check_frame("m0010", 3, 24'hA1_01_23);

    clear_logs();
    pulse_start(1'b0, 4'b1010);
    wait_idle("m1010", 300);
    check("m1010_nconv", ch_log.size(), 2);
    if (ch_log.size() > 1) begin
      check("m1010_ch0", ch_log[0], 1);
      check("m1010_ch1", ch_log[1], 3);
    end
    check_frame("m1010", 6, 48'hA1_01_23_A3_07_89);

    clear_logs();
    pulse_start(1'b0, 4'b0000);
    tick(2);
    check("mask0_busy", busy_o, 0);
    check("mask0_nconv", ch_log.size(), 0);

    // Start during a scan (with a different mask and mode) is ignored.
    clear_logs();
    pulse_start(1'b0, 4'b0001);
    tick(5);
    pulse_start(1'b1, 4'b1111);
    wait_idle("restart", 300);
    check_frame("restart", 3, 24'hA0_0A_BC);
    check("restart_eoa", eoa_cnt, 1);
    tick(10);
    check("restart_stay_idle", busy_o, 0);

    // Continuous mode with a fast transmitter: scans start exactly PERIOD apart.
    clear_logs();
    pulse_start(1'b1, 4'b0011);
    guard = 0;
    while (t0_log.size() < 3 && guard < 7000) begin tick(); guard++; end
    check("cont_nscans", t0_log.size(), 3);
    if (t0_log.size() >= 3) begin
      check("cont_period1", t0_log[1] - t0_log[0], 2000);
      check("cont_period2", t0_log[2] - t0_log[1], 2000);
    end
    check("cont_ovr", ovr_o, 0);
    tx_log.delete(); eoa_cnt = 0;
    pulse_stop();
    wait_idle("cont_stop", 500);
    check_frame("cont_stop", 6, 48'hA0_0A_BC_A1_01_23);
    check("cont_stop_eoa", eoa_cnt, 1);
    check("cont_stop_nscans", t0_log.size(), 3);

    // Slow transmitter: the scan outlasts the period and sets the overrun flag.
    tx_len = 400;
    clear_logs();
    pulse_start(1'b1, 4'b0011);
    guard = 0;
    while (!eoa_o && guard < 6000) begin tick(); guard++; end
    check("ovr_eoa_seen", eoa_o, 1);
    check("ovr_set", ovr_o, 1);
    tick();
    check("ovr_next_busy", busy_o, 1);
    tick();
    check("ovr_next_conv", {spi_start_o, spi_ch_o}, {1'b1, 2'd0});
    pulse_stop();
    wait_idle("ovr_stop", 6000);
    check("ovr_sticky", ovr_o, 1);
    tx_len = 1;
    clear_logs();
    pulse_start(1'b0, 4'b0011);
    check("ovr_cleared", ovr_o, 0);
    wait_idle("ovr_clr_scan", 300);

    // Asynchronous reset while waiting for a byte to finish.
    tx_len = 20;
    clear_logs();
    pulse_start(1'b0, 4'b0011);
    guard = 0;
    while (tx_log.size() < 1 && guard < 100) begin tick(); guard++; end
    check("rst_mid_first_byte", tx_log.size(), 1);
    tick(5);
    #1 rst_i = 1'b0;
    #1 check("rst_mid_outputs",
             {busy_o, spi_start_o, spi_ch_o, tx_start_o, tx_data_o, eoa_o, ovr_o}, 0);
    tick(2);
    rst_i = 1'b1;
    tick();
    tx_len = 1;
    clear_logs();
    pulse_start(1'b0, 4'b0011);
    wait_idle("post_rst", 300);
    check_frame("post_rst", 6, 48'hA0_0A_BC_A1_01_23);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
